// File: rtl/seq_mult_param.sv
// seq_mult_param: iterative shift-add multiplier, STEP bits per cycle, signed/unsigned, optional early exit.
module seq_mult_param #(
    parameter int WIDTH      = 24,
    parameter int STEP       = 1,
    parameter int EARLY_EXIT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   p,
    output logic                 out_en
);
    localparam int N  = WIDTH / STEP;
    localparam int CW = $clog2(N + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state, state_nx;
    logic [2*WIDTH-1:0]   mcand, acc, acc_nx, digit;
    logic [WIDTH-1:0]     mplier, x_abs, y_abs;
    logic [CW-1:0]        cnt;
    logic                 neg, finish;

    // operands are multiplied as magnitudes; the sign is reapplied at the end
    always_comb begin
        x_abs    = (is_signed && x[WIDTH-1]) ? -x : x;
        y_abs    = (is_signed && y[WIDTH-1]) ? -y : y;
        digit    = {{(2*WIDTH-STEP){1'b0}}, mplier[STEP-1:0]};
        acc_nx   = acc + mcand * digit;
        finish   = (cnt == CW'(1)) || ((EARLY_EXIT != 0) && ((mplier >> STEP) == '0));
        state_nx = (state == IDLE) ? (start ? RUN : IDLE) : (finish ? IDLE : RUN);
        busy     = (state == RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
            p      <= '0;
            out_en <= 1'b0;
        end else begin
            state  <= state_nx;
            out_en <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    mcand  <= {{WIDTH{1'b0}}, x_abs};
                    mplier <= y_abs;
                    acc    <= '0;
                    neg    <= is_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
                    cnt    <= CW'(N);
                end
            end else begin
                acc    <= acc_nx;
                mcand  <= mcand << STEP;
                mplier <= mplier >> STEP;
                cnt    <= cnt - CW'(1);
                if (finish) begin
                    p      <= neg ? -acc_nx : acc_nx;
                    out_en <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_mult_param.sv
// tb_seq_mult_param: three configurations (STEP1/EE0, STEP1/EE1, STEP4/EE0) checked against a golden model.
module tb_seq_mult_param;
    localparam int W = 24;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [2:0] start = '0, sgn = '0, busy, out_en;
    logic [W-1:0] x [3];
    logic [W-1:0] y [3];
    logic [2*W-1:0] p [3];

    always #5 clk = ~clk;

    seq_mult_param #(.WIDTH(W), .STEP(1), .EARLY_EXIT(0)) u0 (.clk(clk), .reset(reset), .start(start[0]),
        .is_signed(sgn[0]), .x(x[0]), .y(y[0]), .busy(busy[0]), .p(p[0]), .out_en(out_en[0]));
    seq_mult_param #(.WIDTH(W), .STEP(1), .EARLY_EXIT(1)) u1 (.clk(clk), .reset(reset), .start(start[1]),
        .is_signed(sgn[1]), .x(x[1]), .y(y[1]), .busy(busy[1]), .p(p[1]), .out_en(out_en[1]));
    seq_mult_param #(.WIDTH(W), .STEP(4), .EARLY_EXIT(0)) u2 (.clk(clk), .reset(reset), .start(start[2]),
        .is_signed(sgn[2]), .x(x[2]), .y(y[2]), .busy(busy[2]), .p(p[2]), .out_en(out_en[2]));

    typedef struct {
        int             idx;
        logic           sg;
        logic [W-1:0]   xv;
        logic [W-1:0]   yv;
        logic [2*W-1:0] pe;
        int             le;
    } vec_t;

    typedef struct {
        logic [2*W-1:0] pe;
        int             le;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;
    int n_of[3]    = '{24, 24, 6};
    int ee_of[3]   = '{0, 1, 0};
    int step_of[3] = '{1, 1, 4};

    function automatic logic [2*W-1:0] model(logic [W-1:0] a, logic [W-1:0] b, logic s);
        logic signed [2*W-1:0] sa, sb_;
        if (s) begin
            sa  = {{W{a[W-1]}}, a};
            sb_ = {{W{b[W-1]}}, b};
            return sa * sb_;
        end
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    function automatic int lat(int i, logic [W-1:0] b, logic s);
        logic [W-1:0] m;
        int bl, l;
        if (ee_of[i] == 0) return n_of[i];
        m  = (s && b[W-1]) ? -b : b;
        bl = 0;
        for (int k = 0; k < W; k++) if (m[k]) bl = k + 1;
        l = (bl + step_of[i] - 1) / step_of[i];
        return (l < 1) ? 1 : l;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(int i, logic s, logic [W-1:0] a, logic [W-1:0] b, logic [2*W-1:0] pe, int le);
        start[i] = 1'b1;
        sgn[i]   = s;
        x[i]     = a;
        y[i]     = b;
        @(posedge clk); #1;
        start[i] = 1'b0;
        sb.push_back('{pe, le});
        chk("busy_after_start", 64'(busy[i]), 64'd1);
    endtask

    task automatic collect(int i, string nm, int k0, bit pulse);
        int k = k0;
        exp_t e;
        while (!out_en[i] && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        e = sb.pop_front();
        if (!out_en[i]) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: no out_en after %0d cycles, expected after %0d", nm, k, e.le);
        end else begin
            chk({nm, "_p"}, 64'(p[i]), 64'(e.pe));
            chk({nm, "_lat"}, 64'(k), 64'(e.le));
        end
        if (pulse) begin
            @(posedge clk); #1;
            chk({nm, "_pulse"}, 64'(out_en[i]), 64'd0);
        end
    endtask

    initial begin
        vec_t vt[9];
        int oc;
        for (int i = 0; i < 3; i++) begin
            x[i] = '0;
            y[i] = '0;
        end
        vt[0] = '{0, 1'b0, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 24};
        vt[1] = '{0, 1'b1, 24'h800000, 24'h800000, 48'h400000000000, 24};
        vt[2] = '{0, 1'b1, 24'hFFFFFF, 24'h000003, 48'hFFFFFFFFFFFD, 24};
        vt[3] = '{1, 1'b0, 24'h000005, 24'h000003, 48'h00000000000F, 2};
        vt[4] = '{1, 1'b0, 24'h000005, 24'h000000, 48'h000000000000, 1};
        vt[5] = '{2, 1'b0, 24'h123456, 24'h654321, model(24'h123456, 24'h654321, 1'b0), 6};
        vt[6] = '{1, 1'b1, 24'hFFFFFF, 24'h000003, 48'hFFFFFFFFFFFD, 2};
        vt[7] = '{1, 1'b1, 24'h000000, 24'h800000, 48'h000000000000, 24};
        vt[8] = '{2, 1'b1, 24'h800000, 24'h7FFFFF, model(24'h800000, 24'h7FFFFF, 1'b1), 6};

        #2;
        for (int i = 0; i < 3; i++) begin
            chk("reset_p", 64'(p[i]), 64'd0);
            chk("reset_busy", 64'(busy[i]), 64'd0);
            chk("reset_out_en", 64'(out_en[i]), 64'd0);
        end
        #10 reset = 1'b1;
        @(posedge clk); #1;

        foreach (vt[v]) begin
            issue(vt[v].idx, vt[v].sg, vt[v].xv, vt[v].yv, vt[v].pe, vt[v].le);
            collect(vt[v].idx, $sformatf("vec%0d", v), 0, 1'b1);
        end

        // start and operand changes while busy must be ignored
        issue(0, 1'b0, 24'h00ABCD, 24'h001234, model(24'h00ABCD, 24'h001234, 1'b0), 24);
        repeat (5) begin
            @(posedge clk); #1;
        end
        start[0] = 1'b1;
        sgn[0]   = 1'b1;
        x[0]     = 24'hFFFFFF;
        y[0]     = 24'h7FFFFF;
        @(posedge clk); #1;
        start[0] = 1'b0;
        x[0]     = 24'h555555;
        collect(0, "ignore", 6, 1'b1);

        // back-to-back: start in the out_en cycle
        issue(0, 1'b1, 24'h000007, 24'hFFFFF0, model(24'h000007, 24'hFFFFF0, 1'b1), 24);
        collect(0, "b2b1", 0, 1'b0);
        issue(0, 1'b0, 24'h0F0F0F, 24'h00FF00, model(24'h0F0F0F, 24'h00FF00, 1'b0), 24);
        collect(0, "b2b2", 0, 1'b1);

        // asynchronous reset in the middle of a run
        issue(0, 1'b0, 24'h000123, 24'h000456, 48'd0, 24);
        issue(2, 1'b0, 24'h000789, 24'h000ABC, 48'd0, 6);
        sb.delete();
        repeat (2) begin
            @(posedge clk); #1;
        end
        #2 reset = 1'b0;
        #1;
        chk("arst_p0", 64'(p[0]), 64'd0);
        chk("arst_p2", 64'(p[2]), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_out_en", 64'(out_en), 64'd0);
        #3 reset = 1'b1;
        oc = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_en != 3'b000) oc++;
        end
        chk("arst_no_out_en", 64'(oc), 64'd0);

        for (int r = 0; r < 24; r++) begin
            int i;
            logic s;
            logic [W-1:0] a, b;
            i = $urandom_range(0, 2);
            s = 1'($urandom_range(0, 1));
            a = W'($urandom);
            b = W'($urandom);
            if ($urandom_range(0, 3) == 0) b = b & 24'h0000FF;
            issue(i, s, a, b, model(a, b, s), lat(i, b, s));
            collect(i, $sformatf("rnd%0d", r), 0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
